// File: rtl/video_timing_pkg.sv
// Shared raster timing definitions: phase encoding, 640x480@60 constants
// and the helper that derives line/frame totals from the four segments.
package video_timing_pkg;

    // Phase of one raster axis. The order follows the raster: visible,
    // front porch, sync pulse, back porch.
    typedef enum logic [1:0] {
        ACT  = 2'd0,
        FP   = 2'd1,
        SYNC = 2'd2,
        BP   = 2'd3
    } phase_t;

    // Counter width; both totals must stay at or below 1024.
    localparam int CNT_W = 10;

    // 640x480 at 60 Hz with a 25 MHz pixel clock.
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FRONT  = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BACK   = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FRONT  = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BACK   = 33;

    // Total length of one axis in counter steps.
    function automatic int axis_total(input int active, input int front,
                                      input int sync, input int back);
        return active + front + sync + back;
    endfunction

    localparam int DEF_H_TOTAL = axis_total(DEF_H_ACTIVE, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
    localparam int DEF_V_TOTAL = axis_total(DEF_V_ACTIVE, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);

endpackage

// File: rtl/sync_axis_counter.sv
// One raster axis: a position counter that wraps at the axis total, a phase
// FSM that always describes the value held in the counter, and a wrap strobe
// that lets the next axis step along.
module sync_axis_counter
    import video_timing_pkg::*;
#(
    parameter int P_ACTIVE = DEF_H_ACTIVE,
    parameter int P_FRONT  = DEF_H_FRONT,
    parameter int P_SYNC   = DEF_H_SYNC,
    parameter int P_BACK   = DEF_H_BACK
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt,
    output phase_t           o_phase,
    output logic             o_wrap
);

    localparam int TOTAL = axis_total(P_ACTIVE, P_FRONT, P_SYNC, P_BACK);

    // Counter values at which each phase begins.
    localparam logic [CNT_W-1:0] L_LAST     = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] L_FP_START = CNT_W'(P_ACTIVE);
    localparam logic [CNT_W-1:0] L_SY_START = CNT_W'(P_ACTIVE + P_FRONT);
    localparam logic [CNT_W-1:0] L_BP_START = CNT_W'(P_ACTIVE + P_FRONT + P_SYNC);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_last;
    phase_t           r_phase;
    phase_t           w_phase_next;

    // Next counter value and terminal-count detection.
    always_comb begin
        w_last     = (r_cnt == L_LAST);
        w_cnt_next = w_last ? '0 : r_cnt + 1'b1;
    end

    // Position counter; advances only when enabled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_cnt_next;
        end
    end

    // Phase register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_phase <= ACT;
        end else begin
            r_phase <= w_phase_next;
        end
    end

    // Phase transitions are decided from the value the counter is about to
    // load, so phase and counter always change on the same edge.
    always_comb begin
        w_phase_next = r_phase;
        if (i_en) begin
            case (r_phase)
                ACT:     if (w_cnt_next == L_FP_START) w_phase_next = FP;
                FP:      if (w_cnt_next == L_SY_START) w_phase_next = SYNC;
                SYNC:    if (w_cnt_next == L_BP_START) w_phase_next = BP;
                BP:      if (w_last)                   w_phase_next = ACT;
                default: w_phase_next = ACT;
            endcase
        end
    end

    assign o_cnt   = r_cnt;
    assign o_phase = r_phase;
    assign o_wrap  = i_en & w_last;

endmodule

// File: rtl/vga_sync_gen.sv
// Raster timing generator: chains a horizontal and a vertical axis counter
// and registers position, visibility, sync and strobes in one output stage
// so every output in a cycle describes the same pixel.
module vga_sync_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE        = DEF_H_ACTIVE,
    parameter int H_FRONT         = DEF_H_FRONT,
    parameter int H_SYNC          = DEF_H_SYNC,
    parameter int H_BACK          = DEF_H_BACK,
    parameter int V_ACTIVE        = DEF_V_ACTIVE,
    parameter int V_FRONT         = DEF_V_FRONT,
    parameter int V_SYNC          = DEF_V_SYNC,
    parameter int V_BACK          = DEF_V_BACK,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_ce,
    output logic [CNT_W-1:0] o_hpos,
    output logic [CNT_W-1:0] o_vpos,
    output logic             o_visible,
    output logic             o_hsync,
    output logic             o_vsync,
    output logic             o_line_start,
    output logic             o_frame_start
);

    // Level driven on the sync lines outside the pulse.
    localparam logic L_SYNC_IDLE = (SYNC_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    logic [CNT_W-1:0] w_hcnt;
    logic [CNT_W-1:0] w_vcnt;
    phase_t           w_h_phase;
    phase_t           w_v_phase;
    logic             w_h_wrap;
    logic             w_v_wrap;

    // Set while the counters sit at (0,0) and that pixel has not yet been
    // presented; the frame strobe is issued when it is.
    logic             r_at_origin;

    logic [CNT_W-1:0] r_hpos;
    logic [CNT_W-1:0] r_vpos;
    logic             r_visible;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_line_start;
    logic             r_frame_start;

    sync_axis_counter #(
        .P_ACTIVE (H_ACTIVE),
        .P_FRONT  (H_FRONT),
        .P_SYNC   (H_SYNC),
        .P_BACK   (H_BACK)
    ) u_h_axis (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (i_ce),
        .o_cnt   (w_hcnt),
        .o_phase (w_h_phase),
        .o_wrap  (w_h_wrap)
    );

    // The vertical axis steps once per line, on the horizontal wrap.
    sync_axis_counter #(
        .P_ACTIVE (V_ACTIVE),
        .P_FRONT  (V_FRONT),
        .P_SYNC   (V_SYNC),
        .P_BACK   (V_BACK)
    ) u_v_axis (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (w_h_wrap),
        .o_cnt   (w_vcnt),
        .o_phase (w_v_phase),
        .o_wrap  (w_v_wrap)
    );

    // Origin tracker: any enabled step leaves (0,0) except the frame wrap.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_at_origin <= 1'b1;
        end else if (i_ce) begin
            r_at_origin <= w_v_wrap;
        end
    end

    // Output stage: samples counters and phases on enabled edges; strobes
    // last exactly one clock regardless of i_ce.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hpos        <= '0;
            r_vpos        <= '0;
            r_visible     <= 1'b0;
            r_hsync       <= L_SYNC_IDLE;
            r_vsync       <= L_SYNC_IDLE;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            if (i_ce) begin
                r_hpos        <= w_hcnt;
                r_vpos        <= w_vcnt;
                r_visible     <= (w_h_phase == ACT) && (w_v_phase == ACT);
                r_hsync       <= (w_h_phase == SYNC) ? ~L_SYNC_IDLE : L_SYNC_IDLE;
                r_vsync       <= (w_v_phase == SYNC) ? ~L_SYNC_IDLE : L_SYNC_IDLE;
                r_line_start  <= (w_hcnt == '0);
                r_frame_start <= r_at_origin;
            end
        end
    end

    assign o_hpos        = r_hpos;
    assign o_vpos        = r_vpos;
    assign o_visible     = r_visible;
    assign o_hsync       = r_hsync;
    assign o_vsync       = r_vsync;
    assign o_line_start  = r_line_start;
    assign o_frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a default 640x480 instance (active-low sync) and a
// small 14x7 raster instance (active-high sync). Expected output vectors are
// produced by a position-based reference model and queued per clock.
module tb_vga_sync_gen;

    localparam int D_HA = 640, D_HF = 16, D_HS = 96, D_HB = 48;
    localparam int D_VA = 480, D_VF = 10, D_VS = 2,  D_VB = 33;
    localparam int D_HT = D_HA + D_HF + D_HS + D_HB;
    localparam int D_VT = D_VA + D_VF + D_VS + D_VB;

    localparam int S_HA = 8, S_HF = 2, S_HS = 2, S_HB = 2;
    localparam int S_VA = 4, S_VF = 1, S_VS = 1, S_VB = 1;
    localparam int S_HT = S_HA + S_HF + S_HS + S_HB;
    localparam int S_VT = S_VA + S_VF + S_VS + S_VB;
    localparam int S_FT = S_HT * S_VT;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n;
    logic rst_s_n;
    logic ce_d;
    logic ce_s;

    always #5 clk = ~clk;

    logic [9:0] d_hpos, d_vpos, s_hpos, s_vpos;
    logic       d_visible, d_hsync, d_vsync, d_line_start, d_frame_start;
    logic       s_visible, s_hsync, s_vsync, s_line_start, s_frame_start;
    logic [24:0] d_vec, s_vec;

    assign d_vec = {d_hpos, d_vpos, d_visible, d_hsync, d_vsync, d_line_start, d_frame_start};
    assign s_vec = {s_hpos, s_vpos, s_visible, s_hsync, s_vsync, s_line_start, s_frame_start};

    vga_sync_gen dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_ce          (ce_d),
        .o_hpos        (d_hpos),
        .o_vpos        (d_vpos),
        .o_visible     (d_visible),
        .o_hsync       (d_hsync),
        .o_vsync       (d_vsync),
        .o_line_start  (d_line_start),
        .o_frame_start (d_frame_start)
    );

    vga_sync_gen #(
        .H_ACTIVE (S_HA), .H_FRONT (S_HF), .H_SYNC (S_HS), .H_BACK (S_HB),
        .V_ACTIVE (S_VA), .V_FRONT (S_VF), .V_SYNC (S_VS), .V_BACK (S_VB),
        .SYNC_ACTIVE_LOW (0)
    ) dut_small (
        .i_clk         (clk),
        .i_rst_n       (rst_s_n),
        .i_ce          (ce_s),
        .o_hpos        (s_hpos),
        .o_vpos        (s_vpos),
        .o_visible     (s_visible),
        .o_hsync       (s_hsync),
        .o_vsync       (s_vsync),
        .o_line_start  (s_line_start),
        .o_frame_start (s_frame_start)
    );

    // scoreboard
    int total = 0;
    int bad   = 0;
    logic [24:0] exp_q[$];

    int dm_h, dm_v, sm_h, sm_v;
    logic [24:0] d_last, s_last;

    // Reference: outputs for pixel (h,v) computed from position ranges.
    function automatic logic [24:0] model_vec(input int h, input int v,
                                              input int ha, input int hf, input int hs,
                                              input int va, input int vf, input int vs,
                                              input bit low);
        logic act, hsy, vsy, vis;
        act = low ? 1'b0 : 1'b1;
        hsy = (h >= ha + hf && h < ha + hf + hs) ? act : ~act;
        vsy = (v >= va + vf && v < va + vf + vs) ? act : ~act;
        vis = (h < ha) && (v < va);
        return {10'(h), 10'(v), vis, hsy, vsy, (h == 0), (h == 0 && v == 0)};
    endfunction

    function automatic logic [24:0] reset_vec(input bit low);
        return {20'd0, 1'b0, low, low, 2'b00};
    endfunction

    task automatic check(input string tag, input logic [24:0] obs);
        logic [24:0] e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL %s scoreboard empty, observed=%h", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                bad++;
                $error("FAIL %s observed=%h (h=%0d v=%0d) expected=%h (h=%0d v=%0d)",
                       tag, obs, obs[24:15], obs[14:5], e, e[24:15], e[14:5]);
            end
        end
    endtask

    // driver: one clock on the default instance
    task automatic d_cycle(input bit ce);
        logic [24:0] e;
        ce_d = ce;
        if (ce) begin
            e = model_vec(dm_h, dm_v, D_HA, D_HF, D_HS, D_VA, D_VF, D_VS, 1'b1);
            d_last = e;
            dm_h++;
            if (dm_h == D_HT) begin
                dm_h = 0;
                dm_v = (dm_v + 1) % D_VT;
            end
        end else begin
            e = {d_last[24:2], 2'b00};
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check("dflt", d_vec);
    endtask

    // driver: one clock on the small instance
    task automatic s_cycle(input bit ce);
        logic [24:0] e;
        ce_s = ce;
        if (ce) begin
            e = model_vec(sm_h, sm_v, S_HA, S_HF, S_HS, S_VA, S_VF, S_VS, 1'b0);
            s_last = e;
            sm_h++;
            if (sm_h == S_HT) begin
                sm_h = 0;
                sm_v = (sm_v + 1) % S_VT;
            end
        end else begin
            e = {s_last[24:2], 2'b00};
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check("small", s_vec);
    endtask

    // watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int last_fs;
        int n_fs;

        ce_d = 1'b0; ce_s = 1'b0;
        rst_n = 1'b1; rst_s_n = 1'b1;
        dm_h = 0; dm_v = 0; sm_h = 0; sm_v = 0;
        #2;
        rst_n = 1'b0; rst_s_n = 1'b0;
        #1;

        // reset state of both instances
        d_last = reset_vec(1'b1);
        s_last = reset_vec(1'b0);
        exp_q.push_back(d_last);
        check("rst_dflt", d_vec);
        exp_q.push_back(s_last);
        check("rst_small", s_vec);

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // first line plus first pixel of line 1
        for (int i = 0; i < D_HT + 1; i++) d_cycle(1'b1);

        // alternating enable
        for (int i = 0; i < 40; i++) d_cycle(i % 2 == 1);

        // random enable
        repeat (60) d_cycle(1'($urandom_range(0, 1)));

        // advance to hpos 700, inside the hsync pulse
        n = 0;
        while (d_last[24:15] != 10'd700 && n < 2000) begin
            d_cycle(1'b1);
            n++;
        end
        total++;
        assert (d_hpos === 10'd700 && d_hsync === 1'b0) else begin
            bad++;
            $error("FAIL reach_dflt_sync observed h=%0d hsync=%b expected h=700 hsync=0", d_hpos, d_hsync);
        end

        // asynchronous reset mid-sync, checked before any clock edge
        #2;
        rst_n = 1'b0;
        #1;
        d_last = reset_vec(1'b1);
        dm_h = 0; dm_v = 0;
        exp_q.push_back(d_last);
        check("async_rst_dflt", d_vec);
        #2;
        rst_n = 1'b1;
        repeat (20) d_cycle(1'b1);
        ce_d = 1'b0;

        // small raster: three frames, frame strobe period
        rst_s_n = 1'b1;
        last_fs = -1;
        n_fs = 0;
        for (int c = 0; c < 3 * S_FT; c++) begin
            s_cycle(1'b1);
            if (s_frame_start) begin
                if (last_fs >= 0) begin
                    total++;
                    assert (c - last_fs == S_FT) else begin
                        bad++;
                        $error("FAIL frame_period observed=%0d expected=%0d", c - last_fs, S_FT);
                    end
                end
                last_fs = c;
                n_fs++;
            end
        end
        total++;
        assert (n_fs == 3) else begin
            bad++;
            $error("FAIL frame_count observed=%0d expected=3", n_fs);
        end

        // alternating enable on the small raster
        for (int i = 0; i < 30; i++) s_cycle(i % 2 == 0);

        // advance to (10,5): both sync pulses active
        n = 0;
        while (!(s_last[24:15] == 10'd10 && s_last[14:5] == 10'd5) && n < 300) begin
            s_cycle(1'b1);
            n++;
        end
        total++;
        assert (s_hpos === 10'd10 && s_vpos === 10'd5 && s_hsync === 1'b1 && s_vsync === 1'b1) else begin
            bad++;
            $error("FAIL reach_small_sync observed h=%0d v=%0d hs=%b vs=%b expected h=10 v=5 hs=1 vs=1",
                   s_hpos, s_vpos, s_hsync, s_vsync);
        end

        #2;
        rst_s_n = 1'b0;
        #1;
        s_last = reset_vec(1'b0);
        sm_h = 0; sm_v = 0;
        exp_q.push_back(s_last);
        check("async_rst_small", s_vec);
        #2;
        rst_s_n = 1'b1;
        repeat (S_FT + 5) s_cycle(1'b1);
        ce_s = 1'b0;

        total++;
        assert (exp_q.size() == 0) else begin
            bad++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
